// File: rtl/flag_handshake_decoder.sv
// flag_handshake_decoder: turns a hardware event into a flag-set injection request,
// then waits for the flag to retire and be cleared by software before acknowledging.
module flag_handshake_decoder #(
    parameter int unsigned FLAG_REG = 28,
    parameter int unsigned TIMEOUT  = 64,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             event_i,
    input  logic             inject_grant_i,
    input  logic             wb_we_i,
    input  logic [31:0]      wb_instr_i,
    input  logic [31:0]      wb_data_i,
    output logic             inject_req_o,
    output logic             event_ack_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] dropped_count_o,
    output logic [CNT_W-1:0] timeout_count_o
);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, REQ, INFLIGHT, SET, ACK} state_e;

    state_e           state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [CNT_W-1:0] dropped_q, dropped_d;
    logic [CNT_W-1:0] timeout_q, timeout_d;
    logic             fw, set_seen, clr_seen;
    logic             unused_instr;

    // Only rd matters; any opcode that writes the flag register counts.
    assign fw           = wb_we_i && (wb_instr_i[26:22] == 5'(FLAG_REG));
    assign set_seen     = fw && (|wb_data_i);
    assign clr_seen     = fw && !(|wb_data_i);
    assign unused_instr = ^{wb_instr_i[31:27], wb_instr_i[21:0]};

    always_comb begin
        state_d   = state_q;
        timer_d   = '0;
        dropped_d = dropped_q;
        timeout_d = timeout_q;
        case (state_q)
            IDLE:     if (event_i) state_d = REQ;
            REQ:      if (inject_grant_i) state_d = INFLIGHT;
            INFLIGHT: begin
                timer_d = timer_q + 1'b1;
                if (set_seen) state_d = SET;
                else if (timer_q == TW'(TIMEOUT - 1)) begin
                    state_d = REQ;
                    if (!(&timeout_q)) timeout_d = timeout_q + 1'b1;
                end
            end
            SET:      if (clr_seen) state_d = ACK;
            ACK:      state_d = event_i ? REQ : IDLE;
            default:  state_d = IDLE;
        endcase
        // An event arriving in ACK starts the next handshake, so only mid-handshake states drop.
        if (event_i && (state_q inside {REQ, INFLIGHT, SET}) && !(&dropped_q))
            dropped_d = dropped_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            dropped_q <= '0;
            timeout_q <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            dropped_q <= dropped_d;
            timeout_q <= timeout_d;
        end
    end

    assign inject_req_o    = (state_q == REQ);
    assign event_ack_o     = (state_q == ACK);
    assign busy_o          = (state_q != IDLE);
    assign dropped_count_o = dropped_q;
    assign timeout_count_o = timeout_q;

endmodule

// File: tb/tb_flag_handshake_decoder.sv
// tb_flag_handshake_decoder: scenario tasks with inline checks; expected acknowledge
// cycles are queued when the clearing write is driven and popped when event_ack fires.
module tb_flag_handshake_decoder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        event_in = 1'b0;
    logic        grant = 1'b0;
    logic        wb_we = 1'b0;
    logic [31:0] wb_instr = '0;
    logic [31:0] wb_data = '0;
    logic        inject_req, event_ack, busy;
    logic [7:0]  dropped_count, timeout_count;

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int ack_q[$];

    localparam logic [4:0] OP_ADDI = 5'b00100;
    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_LW   = 5'b10001;

    flag_handshake_decoder #(.FLAG_REG(28), .TIMEOUT(64), .CNT_W(8)) dut (
        .clk_i(clk), .rst_ni(rst_n), .event_i(event_in), .inject_grant_i(grant),
        .wb_we_i(wb_we), .wb_instr_i(wb_instr), .wb_data_i(wb_data),
        .inject_req_o(inject_req), .event_ack_o(event_ack), .busy_o(busy),
        .dropped_count_o(dropped_count), .timeout_count_o(timeout_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (event_ack) begin
            n_tests++;
            if (ack_q.size() == 0) begin
                n_fail++;
                $display("FAIL ack_scoreboard: unexpected event_ack at cycle %0d, none expected", cyc);
            end else begin
                int exp_c;
                exp_c = ack_q.pop_front();
                if (cyc !== exp_c) begin
                    n_fail++;
                    $display("FAIL ack_scoreboard: event_ack at cycle %0d, expected cycle %0d", cyc, exp_c);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        event_in = 1'b0; grant = 1'b0; wb_we = 1'b0; wb_instr = '0; wb_data = '0;
    endtask

    task automatic pulse_event();
        event_in = 1'b1; tick(); event_in = 1'b0;
    endtask

    task automatic pulse_grant();
        grant = 1'b1; tick(); grant = 1'b0;
    endtask

    task automatic wb(input logic we, input logic [4:0] op, input logic [4:0] rd, input logic [31:0] d);
        wb_we = we; wb_instr = {op, rd, 22'h15a3c}; wb_data = d;
        tick();
        wb_we = 1'b0; wb_instr = '0; wb_data = '0;
    endtask

    task automatic clear_expect_ack(input logic [4:0] op);
        ack_q.push_back(cyc + 1);
        wb(1'b1, op, 5'd28, 32'd0);
    endtask

    task automatic to_set();
        pulse_event(); pulse_grant(); wb(1'b1, OP_ADDI, 5'd28, 32'd1);
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        n_tests++;
        if ({inject_req, event_ack, busy, dropped_count, timeout_count} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got req=%b ack=%b busy=%b drop=%0d to=%0d, expected all 0",
                     inject_req, event_ack, busy, dropped_count, timeout_count);
        end
        rst_n = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_nominal();
        pulse_event();
        n_tests++;
        if (inject_req !== 1'b1 || busy !== 1'b1) begin
            n_fail++; $display("FAIL nominal_req: req=%b busy=%b, expected 1 1", inject_req, busy);
        end
        tick();
        n_tests++;
        if (inject_req !== 1'b1) begin
            n_fail++; $display("FAIL nominal_req_hold: req=%b, expected 1", inject_req);
        end
        pulse_grant();
        n_tests++;
        if (inject_req !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL nominal_grant: req=%b busy=%b, expected 0 1", inject_req, busy);
        end
        repeat (3) tick();
        wb(1'b1, OP_ADDI, 5'd28, 32'd1);
        repeat (7) tick();
        n_tests++;
        if (busy !== 1'b1 || event_ack !== 1'b0) begin
            n_fail++; $display("FAIL nominal_set: busy=%b ack=%b, expected 1 0", busy, event_ack);
        end
        clear_expect_ack(OP_ADDI);
        n_tests++;
        if (event_ack !== 1'b1) begin
            n_fail++; $display("FAIL nominal_ack: ack=%b, expected 1", event_ack);
        end
        tick();
        n_tests++;
        if (event_ack !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL nominal_idle: ack=%b busy=%b, expected 0 0", event_ack, busy);
        end
    endtask

    task automatic test_timeout();
        pulse_event(); pulse_grant();
        repeat (63) tick();
        n_tests++;
        if (inject_req !== 1'b0 || timeout_count !== 8'd0) begin
            n_fail++; $display("FAIL timeout_early: req=%b to=%0d, expected 0 0", inject_req, timeout_count);
        end
        tick();
        n_tests++;
        if (inject_req !== 1'b1 || timeout_count !== 8'd1) begin
            n_fail++; $display("FAIL timeout_reinject: req=%b to=%0d, expected 1 1", inject_req, timeout_count);
        end
        pulse_grant();
        wb(1'b1, OP_ADDI, 5'd28, 32'd1);
        clear_expect_ack(OP_ADDI);
        tick();
        n_tests++;
        if (busy !== 1'b0 || timeout_count !== 8'd1) begin
            n_fail++; $display("FAIL timeout_done: busy=%b to=%0d, expected 0 1", busy, timeout_count);
        end
    endtask

    task automatic test_decode();
        wb(1'b1, OP_ADDI, 5'd28, 32'd1);
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL decode_idle_write: busy=%b, expected 0", busy);
        end
        pulse_event(); pulse_grant();
        wb(1'b1, OP_ADDI, 5'd27, 32'd1);
        wb(1'b0, OP_ADDI, 5'd28, 32'd1);
        wb(1'b1, OP_ADD, 5'd28, 32'd0);
        wb(1'b1, OP_ADD, 5'd28, 32'd0);
        n_tests++;
        if (event_ack !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL decode_inflight_filter: ack=%b busy=%b, expected 0 1", event_ack, busy);
        end
        wb(1'b1, OP_ADD, 5'd28, 32'hdeadbeef);
        wb(1'b1, OP_LW, 5'd27, 32'd0);
        n_tests++;
        if (event_ack !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL decode_set_filter: ack=%b busy=%b, expected 0 1", event_ack, busy);
        end
        wb(1'b1, OP_LW, 5'd28, 32'd7);
        clear_expect_ack(OP_LW);
        n_tests++;
        if (event_ack !== 1'b1) begin
            n_fail++; $display("FAIL decode_opcode_ack: ack=%b, expected 1", event_ack);
        end
        tick();
    endtask

    task automatic test_ack_event();
        to_set();
        clear_expect_ack(OP_ADDI);
        event_in = 1'b1;
        tick();
        event_in = 1'b0;
        n_tests++;
        if (inject_req !== 1'b1 || event_ack !== 1'b0 || dropped_count !== 8'd0) begin
            n_fail++; $display("FAIL ack_event_rerequest: req=%b ack=%b drop=%0d, expected 1 0 0",
                               inject_req, event_ack, dropped_count);
        end
        pulse_grant();
        wb(1'b1, OP_ADDI, 5'd28, 32'd1);
        clear_expect_ack(OP_ADDI);
        tick();
    endtask

    task automatic test_set_on_timeout();
        pulse_event(); pulse_grant();
        repeat (63) tick();
        wb(1'b1, OP_ADDI, 5'd28, 32'd1);
        n_tests++;
        if (inject_req !== 1'b0 || busy !== 1'b1 || timeout_count !== 8'd1) begin
            n_fail++; $display("FAIL set_vs_timeout: req=%b busy=%b to=%0d, expected 0 1 1",
                               inject_req, busy, timeout_count);
        end
        clear_expect_ack(OP_ADD);
        tick();
    endtask

    task automatic test_dropped();
        to_set();
        repeat (3) pulse_event();
        n_tests++;
        if (dropped_count !== 8'd3 || inject_req !== 1'b0 || busy !== 1'b1 || event_ack !== 1'b0) begin
            n_fail++; $display("FAIL dropped_three: drop=%0d req=%b busy=%b ack=%b, expected 3 0 1 0",
                               dropped_count, inject_req, busy, event_ack);
        end
        clear_expect_ack(OP_ADDI);
        tick();
        to_set();
        event_in = 1'b1;
        repeat (300) tick();
        event_in = 1'b0;
        n_tests++;
        if (dropped_count !== 8'd255) begin
            n_fail++; $display("FAIL dropped_saturate: drop=%0d, expected 255", dropped_count);
        end
        clear_expect_ack(OP_ADDI);
        tick();
    endtask

    task automatic test_async_reset();
        pulse_event(); pulse_grant();
        repeat (5) tick();
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({inject_req, event_ack, busy, dropped_count, timeout_count} !== 19'd0) begin
            n_fail++; $display("FAIL async_reset_now: req=%b ack=%b busy=%b drop=%0d to=%0d, expected all 0",
                               inject_req, event_ack, busy, dropped_count, timeout_count);
        end
        tick();
        #3 rst_n = 1'b1;
        repeat (3) tick();
        n_tests++;
        if (busy !== 1'b0 || event_ack !== 1'b0 || inject_req !== 1'b0) begin
            n_fail++; $display("FAIL async_reset_release: busy=%b ack=%b req=%b, expected 0 0 0",
                               busy, event_ack, inject_req);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_timeout();
        test_decode();
        test_ack_event();
        test_set_on_timeout();
        test_dropped();
        test_async_reset();
        n_tests++;
        if (ack_q.size() != 0) begin
            n_fail++; $display("FAIL ack_pending: %0d expected acks never seen, expected 0", ack_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
